// File: rtl/arb_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the default widths and the 2-bit winner identifiers that the
// arbiter registers and delays so it can generate the ack and rvalid pulses.
package arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 17;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned VID_RUN_DEF = 4;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_VID  = 2'd1,
    ARB_CPU  = 2'd2,
    ARB_DMA  = 2'd3
  } arb_id_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker shared by the CPU (index 0) and DMA (index 1).
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   req[1:0]     : requests {dma, cpu}
//   advance      : the picked requester was really granted this cycle
//   gnt[1:0]     : one-hot pick (combinational)
// The pointer names the preferred requester when both ask. After a grant it
// moves to the other requester. Reset prefers the CPU.
module arb_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  // After a CPU grant (gnt[0]) the DMA is preferred next, and the reverse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ptr <= 1'b0;
    else if (advance && (|gnt))
      ptr <= gnt[0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets video fetch, the CPU and the DMA loader share one
// synchronous single-port RAM bank.
// Video has fixed top priority. CPU and DMA take turns through arb_rr2.
// The arbiter makes one access per cycle. Read data returns on mem_rdata one
// cycle after the ack.
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   vid_req/addr/ack/rvalid  : video read port (no write)
//   cpu_*                    : CPU req/we/addr/wdata, ack/rvalid
//   dma_*                    : DMA req/we/addr/wdata, ack/rvalid
//   mem_addr/wdata/we        : registered RAM controls
//   mem_rdata                : RAM q, also the shared read-data bus
// Configuration macro ARB_FAIR_EN: after VID_RUN consecutive video grants
// while CPU/DMA wait, the next slot goes to the round-robin winner.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned VID_RUN = VID_RUN_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_id_e    win;      // winner picked from the requests sampled at this edge
  arb_id_e    win_id;   // winner of the previous edge: drives the acks
  arb_id_e    rd_id;    // read winner one edge later: drives the rvalids
  logic [1:0] rr_gnt;
  logic       side_req;
  logic       fair_turn;
  logic       advance;

  assign side_req = cpu_req | dma_req;

  arb_rr2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     ({dma_req, cpu_req}),
    .advance (advance),
    .gnt     (rr_gnt)
  );

`ifdef ARB_FAIR_EN
  localparam int unsigned RUN_W = $clog2(VID_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VID_RUN);

  logic [RUN_W-1:0] vid_run;

  assign fair_turn = (vid_run == RUN_MAX) && side_req;

  // The counter only grows while CPU/DMA are left waiting behind video.
  // Any other outcome restarts the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      vid_run <= '0;
    else if ((win == ARB_VID) && side_req)
      vid_run <= (vid_run == RUN_MAX) ? vid_run : vid_run + 1'b1;
    else
      vid_run <= '0;
  end
`else
  assign fair_turn = 1'b0;
`endif

  always_comb begin
    win = ARB_NONE;
    if (vid_req && !fair_turn)
      win = ARB_VID;
    else if (rr_gnt[0])
      win = ARB_CPU;
    else if (rr_gnt[1])
      win = ARB_DMA;
  end

  assign advance = (win == ARB_CPU) || (win == ARB_DMA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_id    <= ARB_NONE;
      rd_id     <= ARB_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      win_id <= win;
      // Writes never return data. Video always reads, so mem_we is 0 for it.
      rd_id  <= mem_we ? ARB_NONE : win_id;
      unique case (win)
        ARB_VID: begin
          mem_addr <= vid_addr;
          mem_we   <= 1'b0;
        end
        ARB_CPU: begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          mem_we    <= cpu_we;
        end
        ARB_DMA: begin
          mem_addr  <= dma_addr;
          mem_wdata <= dma_wdata;
          mem_we    <= dma_we;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  assign vid_ack    = (win_id == ARB_VID);
  assign cpu_ack    = (win_id == ARB_CPU);
  assign dma_ack    = (win_id == ARB_DMA);
  assign vid_rvalid = (rd_id == ARB_VID);
  assign cpu_rvalid = (rd_id == ARB_CPU);
  assign dma_rvalid = (rd_id == ARB_DMA);

endmodule
